// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register writeback stage (package wb_pkg).
package wb_pkg;

    // Writeback FSM: IDLE has no load in flight, PEND has exactly one.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // RISC-V load funct3 encodings understood by the formatter.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/reg_writeback_load_formatter.sv
// Combinational load formatter: picks the byte/half lane out of an aligned
// 32-bit word and sign- or zero-extends it; LW and unknown funct3 pass through.
module load_formatter
    import wb_pkg::*;
#(
    parameter int DataBitWidth = 32
) (
    input  logic [DataBitWidth-1:0] word,
    input  logic [2:0]              funct3,
    input  logic [1:0]              addr_lo,
    output logic [DataBitWidth-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: byte lane is addr_lo, half lane is addr_lo[1] only.
    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extension according to the load type.
    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(DataBitWidth-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(DataBitWidth-16){half_sel[15]}}, half_sel};
            F3_LBU:  data = {{(DataBitWidth-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(DataBitWidth-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage in front of the register file write port. Merges ALU
// results with one outstanding load, formats load data and flags source
// hazards to decode.
// Optional: define REG_WRITEBACK_BYPASS_EN to add rsX_fwd/rsX_fwd_dat
// forwarding of the current write; busy then only covers the pending load.
//
// Handshakes: alu_ready / ld_req_ready are computed every cycle regardless of
// the matching valid; a transfer happens in a cycle where valid and ready are
// both high at the rising edge. The ALU source must hold its offer until
// accepted. A ld_req while ld_req_ready is low is ignored.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [AddressBitWidth-1:0] alu_rd,
    input  logic [DataBitWidth-1:0]    alu_wd,
    output logic                       alu_ready,
    input  logic                       ld_req,
    input  logic [AddressBitWidth-1:0] ld_rd,
    input  logic [2:0]                 ld_funct3,
    input  logic [1:0]                 ld_addr_lo,
    output logic                       ld_req_ready,
    input  logic                       mem_rsp_valid,
    input  logic [DataBitWidth-1:0]    mem_rsp_data,
    input  logic [AddressBitWidth-1:0] rs1,
    input  logic [AddressBitWidth-1:0] rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
`ifdef REG_WRITEBACK_BYPASS_EN
    output logic                       rs1_fwd,
    output logic [DataBitWidth-1:0]    rs1_fwd_dat,
    output logic                       rs2_fwd,
    output logic [DataBitWidth-1:0]    rs2_fwd_dat,
`endif
    output logic                       ld_pending,
    output state_t                     fsm_state,
    output logic [AddressBitWidth-1:0] rd,
    output logic                       rd_we,
    output logic [DataBitWidth-1:0]    rd_wd
);

    state_t                     state;
    state_t                     state_next;
    logic [AddressBitWidth-1:0] pend_rd;
    logic [2:0]                 pend_f3;
    logic [1:0]                 pend_lo;
    logic                       rsp_take;
    logic                       ld_accept;
    logic                       alu_take;
    logic                       waw_stall;
    logic [DataBitWidth-1:0]    ld_data;

    assign fsm_state = state;

    // A response only counts while a load is outstanding.
    assign rsp_take  = (state == PEND) && mem_rsp_valid;
    assign ld_accept = ld_req && ld_req_ready;
    assign alu_take  = alu_valid && alu_ready;
    // Hold back an ALU write to the pending load's destination so the older
    // load cannot land on top of the younger ALU result.
    assign waw_stall = (state == PEND) && (alu_rd == pend_rd) && (alu_rd != '0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: a response retires the load; a same-cycle request
    // keeps the FSM in PEND with the new load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ld_req) state_next = PEND;
            PEND:    if (mem_rsp_valid && !ld_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and pending flag.
    always_comb begin
        ld_pending   = (state == PEND);
        ld_req_ready = (state == IDLE) || rsp_take;
        alu_ready    = !rsp_take && !waw_stall;
    end

    // Capture the accepted load's destination and formatting controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_rd <= '0;
            pend_f3 <= '0;
            pend_lo <= '0;
        end else if (ld_accept) begin
            pend_rd <= ld_rd;
            pend_f3 <= ld_funct3;
            pend_lo <= ld_addr_lo;
        end
    end

    load_formatter #(
        .DataBitWidth(DataBitWidth)
    ) u_fmt (
        .word   (mem_rsp_data),
        .funct3 (pend_f3),
        .addr_lo(pend_lo),
        .data   (ld_data)
    );

    // Registered write port; load response has priority over the ALU and
    // writes to x0 are suppressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd    <= '0;
            rd_we <= 1'b0;
            rd_wd <= '0;
        end else if (rsp_take) begin
            rd    <= pend_rd;
            rd_we <= (pend_rd != '0);
            rd_wd <= ld_data;
        end else if (alu_take) begin
            rd    <= alu_rd;
            rd_we <= (alu_rd != '0);
            rd_wd <= alu_wd;
        end else begin
            rd_we <= 1'b0;
        end
    end

`ifdef REG_WRITEBACK_BYPASS_EN
    // Forward the write in flight; only the pending load makes a source busy.
    always_comb begin
        rs1_fwd     = rd_we && (rs1 == rd) && (rs1 != '0);
        rs2_fwd     = rd_we && (rs2 == rd) && (rs2 != '0);
        rs1_fwd_dat = rd_wd;
        rs2_fwd_dat = rd_wd;
        rs1_busy    = (rs1 != '0) && (state == PEND) && (rs1 == pend_rd);
        rs2_busy    = (rs2 != '0) && (state == PEND) && (rs2 == pend_rd);
    end
`else
    // Without a bypass the register file shows a write one cycle after rd_we,
    // so the write in flight also makes a source busy.
    always_comb begin
        rs1_busy = (rs1 != '0) &&
                   (((state == PEND) && (rs1 == pend_rd)) || (rd_we && (rs1 == rd)));
        rs2_busy = (rs2 != '0) &&
                   (((state == PEND) && (rs2 == pend_rd)) || (rd_we && (rs2 == rd)));
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_reg_writeback;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        alu_ready;
  logic        ld_req;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_dat, rs2_fwd_dat;
`endif
  logic        ld_pending;
  state_t      fsm_state;
  logic [4:0]  rd;
  logic        rd_we;
  logic [31:0] rd_wd;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  logic [36:0] exp_q[$];
  ld_t         pend_q[$];

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .ld_req(ld_req), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_req_ready(ld_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REG_WRITEBACK_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs1_fwd_dat(rs1_fwd_dat), .rs2_fwd(rs2_fwd), .rs2_fwd_dat(rs2_fwd_dat),
`endif
    .ld_pending(ld_pending), .fsm_state(fsm_state),
    .rd(rd), .rd_we(rd_we), .rd_wd(rd_wd)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    ld_req = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  // Reference formatting from the load rules, using plain arithmetic.
  function automatic logic [31:0] ref_format(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    longint v;
    case (f3)
      3'd0: begin v = (w >> (8 * int'(lo))) % 256;  if (v >= 128)   v = v - 256;   return 32'(v); end
      3'd1: begin v = (w >> (16 * (int'(lo) / 2))) % 65536; if (v >= 32768) v = v - 65536; return 32'(v); end
      3'd4: begin v = (w >> (8 * int'(lo))) % 256;  return 32'(v); end
      3'd5: begin v = (w >> (16 * (int'(lo) / 2))) % 65536; return 32'(v); end
      default: return w;
    endcase
  endfunction

  // Issue a load (IDLE assumed) and leave the bench one cycle after acceptance.
  task automatic issue_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo);
    ld_req = 1; ld_rd = r; ld_funct3 = f3; ld_addr_lo = lo;
    tick();
    ld_req = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    tick(); tick();
    n_checks++; if (rd_we !== 1'b0) $display("FAIL reset_rd_we got=%b exp=0", rd_we); else n_pass++;
    n_checks++; if (rd !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", rd); else n_pass++;
    n_checks++; if (rd_wd !== 32'd0) $display("FAIL reset_rd_wd got=%h exp=0", rd_wd); else n_pass++;
    n_checks++; if (ld_pending !== 1'b0) $display("FAIL reset_ld_pending got=%b exp=0", ld_pending); else n_pass++;
    n_checks++; if (fsm_state !== IDLE) $display("FAIL reset_state got=%0d exp=IDLE", fsm_state); else n_pass++;
    n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL reset_ld_req_ready got=%b exp=1", ld_req_ready); else n_pass++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_wd = 32'h1234;
    #1;
    n_checks++; if (alu_ready !== 1'b1) $display("FAIL alu_ready got=%b exp=1", alu_ready); else n_pass++;
    tick();
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL alu_write got=%b/%0d/%h exp=1/5/00001234", rd_we, rd, rd_wd); else n_pass++;
    alu_rd = 0; alu_wd = 32'hDEAD;
    #1;
    n_checks++; if (alu_ready !== 1'b1) $display("FAIL alu_x0_ready got=%b exp=1", alu_ready); else n_pass++;
    tick();
    alu_valid = 0;
    n_checks++; if (rd_we !== 1'b0) $display("FAIL alu_x0_we got=%b exp=0", rd_we); else n_pass++;
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] w, input logic [4:0] r, input logic [31:0] exp_wd);
    issue_load(r, f3, lo);
    n_checks++; if (ld_pending !== 1'b1) $display("FAIL %s_pending got=%b exp=1", name, ld_pending); else n_pass++;
    n_checks++; if (ld_req_ready !== 1'b0) $display("FAIL %s_req_ready got=%b exp=0", name, ld_req_ready); else n_pass++;
    repeat (5) tick();
    mem_rsp_valid = 1; mem_rsp_data = w;
    tick();
    mem_rsp_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, r, exp_wd})
      $display("FAIL %s_write got=%b/%0d/%h exp=1/%0d/%h", name, rd_we, rd, rd_wd, r, exp_wd); else n_pass++;
    n_checks++; if (ld_pending !== 1'b0) $display("FAIL %s_done got=%b exp=0", name, ld_pending); else n_pass++;
  endtask

  task automatic test_load_format();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [1:0]  lo;
    test_load("lb", F3_LB, 2'd3, 32'h80FF_FF7F, 5'd7, 32'hFFFF_FF80);
    test_load("lbu", F3_LBU, 2'd3, 32'h80FF_FF7F, 5'd7, 32'h0000_0080);
    for (int i = 0; i < 12; i++) begin
      w = $urandom(); f3 = 3'($urandom_range(0, 7)); lo = 2'($urandom_range(0, 3));
      test_load("fmt_rand", f3, lo, w, 5'($urandom_range(1, 31)), ref_format(f3, lo, w));
    end
  endtask

  task automatic test_collision();
    issue_load(5'd10, F3_LW, 2'd0);
    mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA_5555;
    alu_valid = 1; alu_rd = 9; alu_wd = 32'h0000_0099;
    #1;
    n_checks++; if (alu_ready !== 1'b0) $display("FAIL coll_alu_ready got=%b exp=0", alu_ready); else n_pass++;
    tick();
    mem_rsp_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd10, 32'hAAAA_5555})
      $display("FAIL coll_load_first got=%b/%0d/%h exp=1/10/aaaa5555", rd_we, rd, rd_wd); else n_pass++;
    tick();
    alu_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd9, 32'h0000_0099})
      $display("FAIL coll_alu_second got=%b/%0d/%h exp=1/9/00000099", rd_we, rd, rd_wd); else n_pass++;
  endtask

  task automatic test_waw();
    issue_load(5'd4, F3_LW, 2'd0);
    alu_valid = 1; alu_rd = 4; alu_wd = 32'h0000_00A1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (alu_ready !== 1'b0) $display("FAIL waw_stall got=%b exp=0", alu_ready); else n_pass++;
      tick();
      n_checks++; if (rd_we !== 1'b0) $display("FAIL waw_no_write got=%b exp=0", rd_we); else n_pass++;
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h0000_00B2;
    tick();
    mem_rsp_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd4, 32'h0000_00B2})
      $display("FAIL waw_load got=%b/%0d/%h exp=1/4/000000b2", rd_we, rd, rd_wd); else n_pass++;
    tick();
    alu_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd4, 32'h0000_00A1})
      $display("FAIL waw_alu got=%b/%0d/%h exp=1/4/000000a1", rd_we, rd, rd_wd); else n_pass++;
  endtask

  task automatic test_hazard();
    logic exp_n1;
`ifdef REG_WRITEBACK_BYPASS_EN
    exp_n1 = 1'b0;
`else
    exp_n1 = 1'b1;
`endif
    tick();
    issue_load(5'd3, F3_LW, 2'd0);
    rs1 = 3; rs2 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (rs1_busy !== 1'b1) $display("FAIL haz_pend got=%b exp=1", rs1_busy); else n_pass++;
      n_checks++; if (rs2_busy !== 1'b0) $display("FAIL haz_rs2_zero got=%b exp=0", rs2_busy); else n_pass++;
      tick();
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h3333_3333;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) $display("FAIL haz_rsp_cycle got=%b exp=1", rs1_busy); else n_pass++;
    tick();
    mem_rsp_valid = 0;
    #1;
    n_checks++; if (rs1_busy !== exp_n1) $display("FAIL haz_n1 got=%b exp=%b", rs1_busy, exp_n1); else n_pass++;
`ifdef REG_WRITEBACK_BYPASS_EN
    n_checks++; if ({rs1_fwd, rs1_fwd_dat} !== {1'b1, 32'h3333_3333})
      $display("FAIL haz_fwd got=%b/%h exp=1/33333333", rs1_fwd, rs1_fwd_dat); else n_pass++;
`endif
    n_checks++; if (rs2_busy !== 1'b0) $display("FAIL haz_rs2_n1 got=%b exp=0", rs2_busy); else n_pass++;
    tick();
    n_checks++; if (rs1_busy !== 1'b0) $display("FAIL haz_n2 got=%b exp=0", rs1_busy); else n_pass++;
    rs1 = 0;
  endtask

  task automatic test_back_to_back();
    issue_load(5'd11, F3_LH, 2'd2);
    mem_rsp_valid = 1; mem_rsp_data = 32'hC001_1234;
    ld_req = 1; ld_rd = 12; ld_funct3 = F3_LBU; ld_addr_lo = 2'd1;
    #1;
    n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", ld_req_ready); else n_pass++;
    tick();
    ld_req = 0; mem_rsp_data = 32'h0000_F100;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd11, 32'hFFFF_C001})
      $display("FAIL b2b_first got=%b/%0d/%h exp=1/11/ffffc001", rd_we, rd, rd_wd); else n_pass++;
    n_checks++; if (ld_pending !== 1'b1) $display("FAIL b2b_pending got=%b exp=1", ld_pending); else n_pass++;
    tick();
    mem_rsp_valid = 0;
    n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, 5'd12, 32'h0000_00F1})
      $display("FAIL b2b_second got=%b/%0d/%h exp=1/12/000000f1", rd_we, rd, rd_wd); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    issue_load(5'd6, F3_LW, 2'd0);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_checks++; if (ld_pending !== 1'b0) $display("FAIL rst_mid_pending got=%b exp=0", ld_pending); else n_pass++;
    n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", ld_req_ready); else n_pass++;
    mem_rsp_valid = 1; mem_rsp_data = 32'h6666_6666;
    tick();
    mem_rsp_valid = 0;
    n_checks++; if (rd_we !== 1'b0) $display("FAIL rst_mid_no_write got=%b exp=0", rd_we); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic        pend, rsp, exp_ldr, exp_alur, last_we, exp_b1, exp_b2;
    logic [4:0]  last_rd, prd;
    logic [36:0] e;
    ld_t         nl;
    last_we = 0; last_rd = 0;
    exp_q.delete(); pend_q.delete();
    for (int c = 0; c < 400; c++) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 7)); alu_wd = $urandom();
      ld_req = ($urandom_range(0, 3) == 0); ld_rd = 5'($urandom_range(0, 7));
      ld_funct3 = 3'($urandom_range(0, 7)); ld_addr_lo = 2'($urandom_range(0, 3));
      mem_rsp_valid = ($urandom_range(0, 2) == 0); mem_rsp_data = $urandom();
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      #1;
      pend = (pend_q.size() != 0);
      prd = pend ? pend_q[0].rd : 5'd0;
      rsp = pend && mem_rsp_valid;
      exp_ldr = !pend || rsp;
      exp_alur = !rsp && !(pend && alu_rd == prd && alu_rd != 0);
`ifdef REG_WRITEBACK_BYPASS_EN
      exp_b1 = (rs1 != 0) && pend && rs1 == prd;
      exp_b2 = (rs2 != 0) && pend && rs2 == prd;
`else
      exp_b1 = (rs1 != 0) && ((pend && rs1 == prd) || (last_we && rs1 == last_rd));
      exp_b2 = (rs2 != 0) && ((pend && rs2 == prd) || (last_we && rs2 == last_rd));
`endif
      n_checks++; if (alu_ready !== exp_alur) $display("FAIL rnd_alu_ready c=%0d got=%b exp=%b", c, alu_ready, exp_alur); else n_pass++;
      n_checks++; if (ld_req_ready !== exp_ldr) $display("FAIL rnd_ld_ready c=%0d got=%b exp=%b", c, ld_req_ready, exp_ldr); else n_pass++;
      n_checks++; if ({rs1_busy, rs2_busy} !== {exp_b1, exp_b2})
        $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, rs1_busy, rs2_busy, exp_b1, exp_b2); else n_pass++;
      if (rsp) begin
        if (prd != 0) exp_q.push_back({prd, ref_format(pend_q[0].f3, pend_q[0].lo, mem_rsp_data)});
        void'(pend_q.pop_front());
      end else if (alu_valid && exp_alur && alu_rd != 0) begin
        exp_q.push_back({alu_rd, alu_wd});
      end
      if (ld_req && exp_ldr) begin
        nl.rd = ld_rd; nl.f3 = ld_funct3; nl.lo = ld_addr_lo;
        pend_q.push_back(nl);
      end
      tick();
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++; if ({rd_we, rd, rd_wd} !== {1'b1, e})
          $display("FAIL rnd_write c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rd_we, rd, rd_wd, e[36:32], e[31:0]); else n_pass++;
        last_we = 1; last_rd = e[36:32];
      end else begin
        n_checks++; if (rd_we !== 1'b0) $display("FAIL rnd_no_write c=%0d got=%b exp=0", c, rd_we); else n_pass++;
        last_we = 0;
      end
      n_checks++; if (ld_pending !== (pend_q.size() != 0))
        $display("FAIL rnd_pending c=%0d got=%b exp=%b", c, ld_pending, pend_q.size() != 0); else n_pass++;
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_format();
    test_collision();
    test_waw();
    test_hazard();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the register file. Drives its write port (rd, rd_we, rd_wd).
- Merges single-cycle ALU results with multi-cycle load responses from the cache/PSRAM path. Formats load data by size, sign and byte lane.
- Tracks one outstanding load and reports source-register hazards to decode.

Parameters:
AddressBitWidth, 5, register index width
DataBitWidth, 32, register data width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous and active-low
alu_valid  in  1  ALU result offered
alu_rd  in  AddressBitWidth  ALU destination
alu_wd  in  DataBitWidth  ALU result
alu_ready  out  1  ALU result accepted this cycle
ld_req  in  1  load issued to memory
ld_rd  in  AddressBitWidth  load destination
ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
ld_addr_lo  in  2  address bits [1:0]
ld_req_ready  out  1  load request accepted
mem_rsp_valid  in  1  load word returned
mem_rsp_data  in  DataBitWidth  aligned 32-bit word
rs1, rs2  in  AddressBitWidth  decode source indices
rs1_busy, rs2_busy  out  1  source not yet readable from register file
ld_pending  out  1  load outstanding
rd  out  AddressBitWidth  to register file
rd_we  out  1  to register file
rd_wd  out  DataBitWidth  to register file

Behaviour:
- Reset: state IDLE, pend_rd=0, rd=0, rd_we=0, rd_wd=0, ld_pending=0.
- An in-flight load is dropped on reset. A mem_rsp_valid arriving in IDLE is ignored.
- FSM:
  - IDLE --ld_req--> PEND, latching ld_rd, ld_funct3 and ld_addr_lo.
  - PEND --mem_rsp_valid & !ld_req--> IDLE.
  - PEND --mem_rsp_valid & ld_req--> PEND. The new load is latched in the same cycle (back-to-back).
- ld_req_ready = IDLE | (PEND & mem_rsp_valid). A ld_req while not ready is a protocol error; the block ignores it.
- Write outputs are registered with 1-cycle latency: an event accepted in cycle N gives rd_we=1 in cycle N+1.
- Priority: a load response wins. alu_ready = !(PEND & mem_rsp_valid) & !(PEND & alu_rd==pend_rd & alu_rd!=0).
  - The second term is a WAW stall: it prevents an older load overwriting a younger ALU result.
- Any write whose destination is 0 leaves rd_we=0; the ALU result is still accepted.
- Load formatting:
  - Lane = ld_addr_lo for bytes, ld_addr_lo[1] for halves (bit 0 is ignored).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and undefined funct3 values pass the word through unchanged.
- Hazards: rsX_busy = rsX!=0 & ((PEND & rsX==pend_rd) | (rd_we & rsX==rd)).
  - The register file has no internal bypass, so a write is visible only the cycle after rd_we.
  - With a response in cycle N, busy stays high through N+1 and clears in N+2.
- ld_pending = (state==PEND).

Optional Feature:
- Macro: REG_WRITEBACK_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd (1), rs1_fwd_dat (DataBitWidth), rs2_fwd (1), rs2_fwd_dat (DataBitWidth).
  - rsX_fwd = rd_we & rsX==rd & rsX!=0, with rsX_fwd_dat = rd_wd.
  - rsX_busy then covers only the PEND term.
- Undefined: no forward ports; busy includes the rd_we term as above.

Decomposition:
- Package wb_pkg holds:
  - typedef enum state_t {IDLE, PEND};
  - funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
- Sub-module load_formatter: purely combinational. Inputs: word, funct3, addr_lo. Output: formatted data. It is instanced once.

Test Plan:
- ALU only: alu_valid, alu_rd=5, alu_wd=0x1234 → next cycle rd=5, rd_we=1, rd_wd=0x1234. With alu_rd=0 → rd_we=0 and alu_ready=1.
- LB sign-extend: ld_req rd=7, funct3=000, addr_lo=3; response word 0x80FF_FF7F after 6 cycles → rd_wd=0xFFFF_FF80.
  - Same setup with LBU → 0x0000_0080.
- Collision: response and alu_valid (rd=9) in the same cycle → alu_ready=0, load written first; ALU written in the following cycle.
- WAW stall: pending load rd=4, then alu_valid alu_rd=4 → alu_ready=0 until the response. Order in register file: load value, then ALU value.
- Hazard timing: pending load rd=3 with rs1=3 → rs1_busy=1 until two cycles after the response, then 0. rs2=0 → rs2_busy never asserted.
- Reset mid-load: rst_n low while PEND, then mem_rsp_valid arrives → no rd_we, ld_pending=0, ld_req_ready=1.
